// File: rtl/reorder_buffer_pkg.sv
// Shared types for the reorder buffer: slot record, per-slot forwarding view and flush request.
package rv32i_types;

    localparam int ROB_TAG_W  = 4;
    localparam int ROB_DATA_W = 32;
    localparam int ROB_RD_W   = 5;

    typedef struct packed {
        logic [ROB_TAG_W-1:0]  tag;
        logic [ROB_DATA_W-1:0] data;
        logic                  rdy;
    } sal_t;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] front_tag;
        logic [ROB_TAG_W-1:0] flush_tag;
    } flush_t;

    typedef struct packed {
        logic                  busy;
        logic                  rdy;
        logic                  br;
        logic                  mispredict;
        logic [ROB_RD_W-1:0]   rd;
        logic [ROB_DATA_W-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_ptr.sv
// Modulo-size ring pointer with increment and a load used to redirect on flush.
module rob_ptr
    import rv32i_types::*;
#(
    parameter int size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 load,
    input  logic [ROB_TAG_W-1:0] load_val,
    output logic [ROB_TAG_W-1:0] ptr,
    output logic [ROB_TAG_W-1:0] ptr_next1
);

    assign ptr_next1 = (ptr == ROB_TAG_W'(size - 1)) ? '0 : ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (load)
            ptr <= load_val;
        else if (inc)
            ptr <= ptr_next1;
    end

endmodule

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: tag allocation, writeback capture, single-wide commit, precise flush.
// Defining ROB_PERF_EN adds perf_commits / perf_flushes event counters.
module reorder_buffer
    import rv32i_types::*;
#(
    parameter int width = 32,
    parameter int size  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_valid,
    input  logic [ROB_RD_W-1:0]  alloc_rd,
    input  logic                 alloc_br,
    output logic [ROB_TAG_W-1:0] alloc_tag,
    output logic                 full,
    output logic                 empty,
    input  logic                 wb_valid,
    input  logic [ROB_TAG_W-1:0] wb_tag,
    input  logic [width-1:0]     wb_data,
    input  logic                 wb_mispredict,
    output sal_t                 rdest  [size],
    output logic [ROB_RD_W-1:0]  rd_bus [size],
    output logic                 commit_valid,
    output flush_t               flush
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]          perf_commits,
    output logic [31:0]          perf_flushes
`endif
);

    localparam int IDX_W = $clog2(size);

    rob_entry_t           slots [size];
    logic [ROB_TAG_W:0]   count;
    logic [ROB_TAG_W-1:0] front, rear, front_next1, rear_next1;
    logic [IDX_W-1:0]     front_idx, rear_idx, wb_idx;
    logic                 flush_valid, do_alloc, do_wb;

    assign front_idx = front[IDX_W-1:0];
    assign rear_idx  = rear[IDX_W-1:0];
    assign wb_idx    = wb_tag[IDX_W-1:0];

    assign commit_valid = slots[front_idx].busy & slots[front_idx].rdy;
    assign flush_valid  = commit_valid & slots[front_idx].mispredict;
    assign full         = (count == (ROB_TAG_W + 1)'(size));
    assign empty        = (count == '0);
    assign alloc_tag    = rear;
    assign do_alloc     = alloc_valid & ~full & ~flush_valid;
    // Tags beyond the configured depth address no slot and are dropped like a non-busy writeback.
    assign do_wb        = wb_valid & (int'(wb_tag) < size) & slots[wb_idx].busy & ~flush_valid;

    always_comb begin
        flush.valid     = flush_valid;
        flush.front_tag = flush_valid ? front_next1 : front;
        flush.flush_tag = rear;
    end

    always_comb begin
        for (int i = 0; i < size; i++) begin
            rdest[i].tag  = ROB_TAG_W'(i);
            rdest[i].data = slots[i].data;
            rdest[i].rdy  = slots[i].busy & slots[i].rdy;
            rd_bus[i]     = slots[i].rd;
        end
    end

    rob_ptr #(.size(size)) u_front (
        .clk(clk), .rst(rst), .inc(commit_valid), .load(flush_valid),
        .load_val(front_next1), .ptr(front), .ptr_next1(front_next1)
    );

    rob_ptr #(.size(size)) u_rear (
        .clk(clk), .rst(rst), .inc(do_alloc), .load(flush_valid),
        .load_val(front_next1), .ptr(rear), .ptr_next1(rear_next1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < size; i++)
                slots[i] <= '0;
            count <= '0;
        end else if (flush_valid) begin
            for (int i = 0; i < size; i++) begin
                slots[i].busy       <= 1'b0;
                slots[i].rdy        <= 1'b0;
                slots[i].mispredict <= 1'b0;
            end
            count <= '0;
        end else begin
            if (do_wb) begin
                slots[wb_idx].data       <= ROB_DATA_W'(wb_data);
                slots[wb_idx].rdy        <= 1'b1;
                slots[wb_idx].mispredict <= wb_mispredict & slots[wb_idx].br;
            end
            if (do_alloc) begin
                slots[rear_idx].busy       <= 1'b1;
                slots[rear_idx].rdy        <= 1'b0;
                slots[rear_idx].br         <= alloc_br;
                slots[rear_idx].mispredict <= 1'b0;
                slots[rear_idx].rd         <= alloc_rd;
            end
            // Retirement clear comes last so it wins over any writeback to the head slot.
            if (commit_valid) begin
                slots[front_idx].busy <= 1'b0;
                slots[front_idx].rdy  <= 1'b0;
            end
            if (do_alloc && !commit_valid)
                count <= count + 1'b1;
            else if (!do_alloc && commit_valid)
                count <= count - 1'b1;
        end
    end

`ifdef ROB_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_commits <= '0;
            perf_flushes <= '0;
        end else begin
            if (commit_valid)
                perf_commits <= perf_commits + 1'b1;
            if (flush_valid)
                perf_flushes <= perf_flushes + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (size 8, width 32).
module tb_reorder_buffer;
    import rv32i_types::*;

    localparam int SIZE = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 alloc_valid;
    logic [4:0]           alloc_rd;
    logic                 alloc_br;
    logic [3:0]           alloc_tag;
    logic                 full, empty;
    logic                 wb_valid;
    logic [3:0]           wb_tag;
    logic [31:0]          wb_data;
    logic                 wb_mispredict;
    sal_t                 rdest  [SIZE];
    logic [4:0]           rd_bus [SIZE];
    logic                 commit_valid;
    flush_t               flush;
`ifdef ROB_PERF_EN
    logic [31:0]          perf_commits, perf_flushes;
`endif

    int vectors    = 0;
    int miscompares = 0;

    reorder_buffer #(.width(32), .size(SIZE)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_br(alloc_br),
        .alloc_tag(alloc_tag), .full(full), .empty(empty),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_mispredict(wb_mispredict),
        .rdest(rdest), .rd_bus(rd_bus), .commit_valid(commit_valid), .flush(flush)
`ifdef ROB_PERF_EN
        , .perf_commits(perf_commits), .perf_flushes(perf_flushes)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wb(input logic [3:0] t, input logic [31:0] d, input logic m);
        wb_valid = 1'b1; wb_tag = t; wb_data = d; wb_mispredict = m;
        tick();
        wb_valid = 1'b0; wb_mispredict = 1'b0;
    endtask

    initial begin
        alloc_valid = 0; alloc_rd = 0; alloc_br = 0;
        wb_valid = 0; wb_tag = 0; wb_data = 0; wb_mispredict = 0;

        // reset values
        do_reset();
        chk("rst_alloc_tag", 32'(alloc_tag), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_commit", 32'(commit_valid), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_rdest3_tag", 32'(rdest[3].tag), 3);
        chk("rst_rd_bus3", 32'(rd_bus[3]), 0);

        // single alloc, then in-order commit with out-of-order writeback
        alloc_valid = 1; alloc_rd = 5;
        tick();
        alloc_rd = 6;
        chk("a0_rd_bus0", 32'(rd_bus[0]), 5);
        chk("a0_rdy0", 32'(rdest[0].rdy), 0);
        chk("a0_empty", 32'(empty), 0);
        chk("a0_alloc_tag", 32'(alloc_tag), 1);
        tick();
        alloc_valid = 0;
        wb(4'd1, 32'hAA, 1'b0);
        chk("ooo_no_commit", 32'(commit_valid), 0);
        chk("ooo_rdest1_data", rdest[1].data, 32'hAA);
        chk("ooo_rdest1_rdy", 32'(rdest[1].rdy), 1);
        wb(4'd0, 32'h55, 1'b0);
        chk("ooo_commit0", 32'(commit_valid), 1);
        chk("ooo_front0", 32'(flush.front_tag), 0);
        chk("ooo_rdest0_data", rdest[0].data, 32'h55);
        tick();
        chk("ooo_commit1", 32'(commit_valid), 1);
        chk("ooo_front1", 32'(flush.front_tag), 1);
        tick();
        chk("ooo_drained_empty", 32'(empty), 1);
        chk("ooo_drained_commit", 32'(commit_valid), 0);
        chk("ooo_front2", 32'(flush.front_tag), 2);

        // fill, refused alloc, commit-same-cycle refusal, wrap
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < SIZE; i++) begin
            alloc_rd = 5'(i + 1);
            tick();
        end
        chk("fill_full", 32'(full), 1);
        chk("fill_alloc_tag", 32'(alloc_tag), 0);
        alloc_rd = 9;
        tick();
        chk("fill_9th_full", 32'(full), 1);
        chk("fill_9th_rd0", 32'(rd_bus[0]), 1);
        wb(4'd0, 32'h1, 1'b0);
        chk("fill_commit_full", 32'(full), 1);
        chk("fill_commit_valid", 32'(commit_valid), 1);
        tick();
        chk("fill_after_commit_full", 32'(full), 0);
        chk("fill_after_commit_tag", 32'(alloc_tag), 0);
        chk("fill_refused_rd0", 32'(rd_bus[0]), 1);
        tick();
        alloc_valid = 0;
        chk("wrap_rd0", 32'(rd_bus[0]), 9);
        chk("wrap_full", 32'(full), 1);
        chk("wrap_alloc_tag", 32'(alloc_tag), 1);

        // mispredict at tag 2 with 3..5 behind
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < 6; i++) begin
            alloc_rd = 5'(i + 1);
            alloc_br = (i == 2);
            tick();
        end
        alloc_valid = 0; alloc_br = 0;
        wb(4'd0, 32'h10, 1'b0);
        wb(4'd1, 32'h11, 1'b0);
        wb(4'd2, 32'h12, 1'b1);
        chk("br_flush_valid", 32'(flush.valid), 1);
        chk("br_front_tag", 32'(flush.front_tag), 3);
        chk("br_flush_tag", 32'(flush.flush_tag), 6);
        chk("br_commit", 32'(commit_valid), 1);
        alloc_valid = 1; alloc_rd = 31;
        wb_valid = 1; wb_tag = 3; wb_data = 32'hDEAD;
        tick();
        alloc_valid = 0; wb_valid = 0;
        chk("br_after_flush_valid", 32'(flush.valid), 0);
        chk("br_after_empty", 32'(empty), 1);
        chk("br_after_alloc_tag", 32'(alloc_tag), 3);
        chk("br_after_front", 32'(flush.front_tag), 3);
        chk("br_after_rear", 32'(flush.flush_tag), 3);
        chk("br_dropped_wb_rdy", 32'(rdest[3].rdy), 0);
        chk("br_dropped_wb_data", rdest[3].data, 0);
        chk("br_dropped_alloc_rd", 32'(rd_bus[3]), 4);

        // wrapped flush range with head at 6 and full buffer
        do_reset();
        alloc_valid = 1;
        for (int i = 0; i < 6; i++) begin
            alloc_rd = 5'(i);
            tick();
        end
        alloc_valid = 0;
        for (int k = 0; k < 6; k++)
            wb(4'(k), 32'h100 + 32'(k), 1'b0);
        tick();
        chk("wrap_pre_empty", 32'(empty), 1);
        chk("wrap_pre_front", 32'(flush.front_tag), 6);
        alloc_valid = 1;
        for (int i = 0; i < SIZE; i++) begin
            alloc_rd = 5'(i + 10);
            alloc_br = (i == 0);
            tick();
        end
        alloc_br = 0;
        chk("wflush_full", 32'(full), 1);
        chk("wflush_alloc_tag", 32'(alloc_tag), 6);
        wb(4'd6, 32'h66, 1'b1);
        chk("wflush_valid", 32'(flush.valid), 1);
        chk("wflush_front_tag", 32'(flush.front_tag), 7);
        chk("wflush_flush_tag", 32'(flush.flush_tag), 6);
        tick();
        alloc_valid = 0;
        chk("wflush_after_empty", 32'(empty), 1);
        chk("wflush_after_full", 32'(full), 0);
        chk("wflush_after_alloc_tag", 32'(alloc_tag), 7);
`ifdef ROB_PERF_EN
        chk("perf_flushes", perf_flushes, 1);
        chk("perf_commits", perf_commits, 7);
`endif

        // writeback to a non-busy slot is ignored
        wb(4'd4, 32'h1234, 1'b0);
        chk("nobusy_rdy4", 32'(rdest[4].rdy), 0);
        chk("nobusy_data4", rdest[4].data, 32'h104);
        chk("nobusy_empty", 32'(empty), 1);

        // reset mid-stream
        alloc_valid = 1; alloc_rd = 20;
        tick();
        tick();
        alloc_valid = 0;
        wb(4'd7, 32'h77, 1'b0);
        chk("mid_commit_before_rst", 32'(commit_valid), 1);
        do_reset();
        chk("mid_rst_commit", 32'(commit_valid), 0);
        chk("mid_rst_empty", 32'(empty), 1);
        chk("mid_rst_alloc_tag", 32'(alloc_tag), 0);
        chk("mid_rst_rd7", 32'(rd_bus[7]), 0);
        chk("mid_rst_data4", rdest[4].data, 0);
        chk("mid_rst_flush", 32'(flush), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
